rr_arb4: RTL and testbench
==========================

// Module: rr_arb4
// PURPOSE
//   Four-requester round-robin arbiter that owns the select of the shared 4:1 data mux.
//   It grants one requester at a time with a locking grant and drives mux select sel[1:0].
//   It sits between the requesting units and the 4:1 mux; its outputs are registered.
// PARAMETERS
//   MAX_HOLD  16  max consecutive grant cycles per owner (used only with ARB_TIMEOUT_EN)
//   CNT_W     4   hold-counter width; 2**CNT_W >= MAX_HOLD required; MAX_HOLD >= 2
// PORTS
//   clk      in   1  single clock, all state updates on rising edge
//   rst      in   1  synchronous reset, active-high
//   req      in   4  request, bit i = requester i; held high until requester is done
//   gnt      out  4  one-hot grant, registered; all-zero when idle
//   sel      out  2  mux select = index of current/last owner, registered
//   valid    out  1  1 while a grant is active (== |gnt)
//   timeout  out  1  1-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, gnt=0, sel=0, valid=0, timeout=0, last=3, cnt=0.
//     rst overrides everything, including an active grant mid-transfer.
//   Priority: search order starts at (last+1) mod 4 and wraps (e.g. last=2 -> 3,0,1,2).
//     After reset, requester 0 has top priority.
//   IDLE: if req!=0 at edge n, winner w is chosen; gnt=1<<w, sel=w, last=w, state=GRANT
//     visible after edge n (1-cycle latency). If req==0, stay IDLE with outputs unchanged.
//   GRANT (owner o): if req[o]=1, hold gnt/sel unchanged (locking) and cnt++.
//     if req[o]=0: re-arbitrate over req in the same cycle, search starting at o+1.
//       With a winner: grant it after the edge, back-to-back with zero dead cycles, cnt=0.
//       With no winner: go IDLE with gnt=0, valid=0, sel holding o.
//   Requests from non-owners never preempt the owner (except on timeout).
//   Simultaneous requests: exactly one grant, chosen by rotating order; gnt always one-hot or 0.
//   req changes on non-owner bits while in GRANT: ignored until re-arbitration.
//   Owner drops then re-raises req: it is ranked last in the next search (fairness).
//   sel changes only when a new grant is issued; it never changes in IDLE.
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     cnt counts owner cycles. When req[o]=1 and cnt==MAX_HOLD-1, force re-arbitration.
//       The forced search excludes o.
//       With another winner: grant it and pulse timeout=1 for one cycle.
//       Without another winner: o keeps grant, cnt=0, timeout=0.
//   ARB_TIMEOUT_EN undefined: no counter logic; timeout tied 0; grant held indefinitely.
// STRUCTURE
//   Shared include arb_defs.vh holds:
//     state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
//     NREQ=4, IDX_W=2
//   Sub-module rr_pick4 (combinational): inputs req[3:0], start[1:0], mask[3:0].
//     Outputs found and idx[1:0] (first set bit from start, wrapping).
//   Top module holds state, last/owner, cnt, and output registers.
// TESTING
//   1 reset, req=4'b0000 for 5 cycles -> gnt=0, sel=0, valid=0 throughout
//   2 req=4'b1111 from reset, each owner drops req 2 cycles after its grant
//     -> grants 0,1,2,3,0 with no idle cycle between them; sel follows 0,1,2,3
//   3 req=4'b0100 at cycle n -> gnt=4'b0100, sel=2 after edge n
//     then req[1] rises while owner holds -> gnt unchanged until req[2] falls, then gnt=4'b0010
//   4 rst asserted while gnt=4'b1000 -> next cycle gnt=0, sel=0
//     then req=4'b1001 -> gnt=4'b0001 (requester 0 first)
//   5 ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held -> owner 0 for 4 cycles
//     then gnt=4'b0010 with timeout=1 for one cycle; with req=4'b0001 only, owner 0 kept, timeout=0
//   6 without ARB_TIMEOUT_EN, same stimulus as 5 -> owner 0 held indefinitely, timeout=0

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// Shared definitions for the rr_arb4 round-robin arbiter: state encoding,
// requester count and index width, plus a one-hot decode helper.
package rr_arb4_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arb4_pick.sv
// rr_pick4: combinational rotating priority search. Returns the first set bit
// of (req & mask), starting at index 'start' and wrapping around.
module rr_pick4
  import rr_arb4_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] start,
  input  logic [NREQ-1:0]  mask,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [NREQ-1:0]  cand_req;
  logic [IDX_W-1:0] cand;

  assign cand_req = req & mask;

  // Walk from the farthest offset down to offset 0 so the nearest hit wins.
  always_comb begin
    // NOTE: every combinationally driven variable gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = start + IDX_W'(k);
      if (cand_req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: four-requester round-robin arbiter with locking grant driving a
// shared 4:1 mux select. Optional hold timeout enabled by ARB_TIMEOUT_EN.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic        valid,
  output logic        timeout
);

  if (MAX_HOLD < 2 || (2 ** CNT_W) < MAX_HOLD) begin : g_bad_cfg
    $error("rr_arb4: need MAX_HOLD >= 2 and 2**CNT_W >= MAX_HOLD");
  end

  state_t           state, state_d;
  logic [IDX_W-1:0] last, last_d;
  logic [NREQ-1:0]  gnt_d;
  logic [IDX_W-1:0] sel_d;
  logic             new_grant;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [NREQ-1:0]  pick_mask;

  // The current owner is never a candidate while granted: when it has dropped
  // req the mask is moot, and a forced release must exclude it.
  assign pick_mask = (state == ST_GRANT) ? ~onehot(last) : '1;

  rr_pick4 u_pick (
    .req   (req),
    .start (last + IDX_W'(1)),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             timeout_d;
`endif

  always_comb begin
    state_d   = state;
    last_d    = last;
    gnt_d     = gnt;
    sel_d     = sel;
    new_grant = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt;
    timeout_d = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (pick_found) new_grant = 1'b1;
      end
      ST_GRANT: begin
        if (!req[last]) begin
          if (pick_found) begin
            new_grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(MAX_HOLD - 1)) begin
          cnt_d = '0;
          if (pick_found) begin
            new_grant = 1'b1;
            timeout_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (new_grant) begin
      state_d = ST_GRANT;
      gnt_d   = onehot(pick_idx);
      sel_d   = pick_idx;
      last_d  = pick_idx;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      last  <= IDX_W'(NREQ - 1);
      gnt   <= '0;
      sel   <= '0;
    end else begin
      state <= state_d;
      last  <= last_d;
      gnt   <= gnt_d;
      sel   <= sel_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      timeout <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign valid = |gnt;

endmodule

// File: tb/tb_rr_arb4.sv
// Scoreboard bench for rr_arb4: the driver queues the expected registered
// outputs for each edge, a monitor pops and compares them after the edge.
module tb_rr_arb4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       timeout;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  rr_arb4 #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .timeout (timeout)
  );

  // Apply inputs for the next edge and queue the outputs expected after it.
  task automatic drive(input logic [3:0] r, input logic rs,
                       input logic [3:0] eg, input logic [1:0] es,
                       input logic et);
    exp_t e;
    @(negedge clk);
    req = r;
    rst = rs;
    e.gnt = eg;
    e.sel = es;
    e.to  = et;
    q.push_back(e);
  endtask

  // Monitor: compares after each rising edge whenever a response is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (gnt !== e.gnt || sel !== e.sel || timeout !== e.to ||
            valid !== (e.gnt != 4'b0000)) begin
          fails++;
          $display("FAIL step%0d: got gnt=%b sel=%0d valid=%b timeout=%b, want gnt=%b sel=%0d valid=%b timeout=%b",
                   checks, gnt, sel, valid, timeout, e.gnt, e.sel,
                   (e.gnt != 4'b0000), e.to);
        end
      end
    end
  end

  initial begin
    // Reset, then idle with no requests.
    drive(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) drive(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // All request; each owner drops two cycles after its grant.
    drive(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
    drive(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
    drive(4'b1110, 1'b0, 4'b0010, 2'd1, 1'b0);
    drive(4'b1110, 1'b0, 4'b0010, 2'd1, 1'b0);
    drive(4'b1100, 1'b0, 4'b0100, 2'd2, 1'b0);
    drive(4'b1100, 1'b0, 4'b0100, 2'd2, 1'b0);
    drive(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0);
    drive(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0);
    drive(4'b0111, 1'b0, 4'b0001, 2'd0, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // Locking: a non-owner request waits; sel holds through idle.
    drive(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
    drive(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b0);
    drive(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b0);
    drive(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);

    // Reset mid-grant; requester 0 wins afterwards.
    drive(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0);
    drive(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0);
    drive(4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0);
    drive(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0);
    drive(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0);

    // Fairness: owner 0 drops and re-raises, ranked behind requester 1.
    drive(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0);
    drive(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
    drive(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0);
    drive(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    // Hold limit with a competing requester (MAX_HOLD=4).
    drive(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) drive(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    drive(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1);
    drive(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);
`else
    for (int i = 0; i < 4; i++) drive(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
`endif

    // Hold limit with no competitor: owner 0 keeps the grant, no pulse.
    drive(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    for (int i = 0; i < 7; i++) drive(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0);
    drive(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d responses still queued, want 0", q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
